// File: rtl/seg_disp_ctrl.sv
// Seven-segment display front end: holds four 32-bit sources, selects one
// manually or by timed rotation, converts it to 8-digit packed BCD with a
// sequential double-dabble engine and publishes it with a one-cycle strobe.
module seg_disp_ctrl #(
  parameter int unsigned ROT_CYCLES = 200000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   src_wr,
  input  logic [127:0] src_data,
  input  logic [1:0]   manual_sel,
  input  logic         auto_rot,
  output logic         busy,
  output logic [31:0]  disp_bcd,
  output logic [7:0]   disp_blank,
  output logic [1:0]   disp_src,
  output logic         disp_ovf,
  output logic         disp_upd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] ROT_LAST = 32'(ROT_CYCLES - 32'd1);

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added
  // so that the following left shift carries correctly into the next digit.
  function automatic logic [39:0] bcd_adj(input logic [39:0] a);
    logic [39:0] r;
    r = a;
    for (int k = 0; k < 10; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = a[4*k +: 4];
      end
    end
    return r;
  endfunction

  logic [31:0] src_reg_r [4];
  logic [3:0]  dirty_r;
  logic [1:0]  cur_src_r;
  logic [31:0] rot_cnt_r;
  logic        auto_rot_q_r;
  state_t      state_r, state_nxt_s;
  logic [31:0] bin_r, bin_nxt_s;
  logic [39:0] acc_r, acc_nxt_s;
  logic [4:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [1:0]  conv_src_r, conv_src_nxt_s;
  logic        clr_dirty_s, ld_out_s, trig_s, ovf_s;
  logic [3:0]  clr_mask_s;
  logic [39:0] adj_s;
  logic [71:0] shift_s;
  logic [7:0]  blank_s;

  logic        busy_r, disp_ovf_r, disp_upd_r;
  logic [31:0] disp_bcd_r;
  logic [7:0]  disp_blank_r;
  logic [1:0]  disp_src_r;

  assign trig_s     = dirty_r[cur_src_r] | (cur_src_r != disp_src_r);
  assign clr_mask_s = clr_dirty_s ? (4'b0001 << cur_src_r) : 4'b0000;
  assign adj_s      = bcd_adj(acc_r);
  assign shift_s    = {adj_s[38:0], bin_r, 1'b0};
  assign ovf_s      = (acc_r[39:32] != 8'd0);

  // Source registers and dirty flags; a write in the snapshot cycle keeps dirty set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) src_reg_r[i] <= 32'd0;
      dirty_r <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (src_wr[i]) src_reg_r[i] <= src_data[32*i +: 32];
      end
      dirty_r <= (dirty_r & ~clr_mask_s) | src_wr;
    end
  end

  // Source selection: manual follow, or timed rotation with counter cleared on mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src_r    <= 2'd0;
      rot_cnt_r    <= 32'd0;
      auto_rot_q_r <= 1'b0;
    end else begin
      auto_rot_q_r <= auto_rot;
      if (!auto_rot) begin
        cur_src_r <= manual_sel;
        rot_cnt_r <= 32'd0;
      end else if (auto_rot != auto_rot_q_r) begin
        rot_cnt_r <= 32'd0;
      end else if (rot_cnt_r == ROT_LAST) begin
        rot_cnt_r <= 32'd0;
        cur_src_r <= cur_src_r + 2'd1;
      end else begin
        rot_cnt_r <= rot_cnt_r + 32'd1;
      end
    end
  end

  // Conversion FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bin_r      <= 32'd0;
      acc_r      <= 40'd0;
      bit_cnt_r  <= 5'd0;
      conv_src_r <= 2'd0;
    end else begin
      state_r    <= state_nxt_s;
      bin_r      <= bin_nxt_s;
      acc_r      <= acc_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      conv_src_r <= conv_src_nxt_s;
    end
  end

  // Next-state logic: snapshot in IDLE, 32 add-3/shift steps, then publish.
  always_comb begin
    state_nxt_s    = state_r;
    bin_nxt_s      = bin_r;
    acc_nxt_s      = acc_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    conv_src_nxt_s = conv_src_r;
    clr_dirty_s    = 1'b0;
    ld_out_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_nxt_s    = ST_SHIFT;
          bin_nxt_s      = src_reg_r[cur_src_r];
          acc_nxt_s      = 40'd0;
          bit_cnt_nxt_s  = 5'd0;
          conv_src_nxt_s = cur_src_r;
          clr_dirty_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_nxt_s     = shift_s[71:32];
        bin_nxt_s     = shift_s[31:0];
        bit_cnt_nxt_s = bit_cnt_r + 5'd1;
        if (bit_cnt_r == 5'd31) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        ld_out_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Leading-zero blanking: digit k blanks when digits k..7 are zero and no overflow.
  always_comb begin
    logic zero_run;
    blank_s  = 8'h00;
    zero_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_run   = zero_run & (acc_r[4*k +: 4] == 4'd0);
      blank_s[k] = zero_run & ~ovf_s;
    end
  end

  // Registered display outputs, loaded only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      disp_bcd_r   <= 32'd0;
      disp_blank_r <= 8'hFE;
      disp_src_r   <= 2'd0;
      disp_ovf_r   <= 1'b0;
      disp_upd_r   <= 1'b0;
    end else begin
      busy_r     <= (state_nxt_s != ST_IDLE);
      disp_upd_r <= ld_out_s;
      if (ld_out_s) begin
        disp_bcd_r   <= acc_r[31:0];
        disp_ovf_r   <= ovf_s;
        disp_blank_r <= blank_s;
        disp_src_r   <= conv_src_r;
      end
    end
  end

  assign busy       = busy_r;
  assign disp_bcd   = disp_bcd_r;
  assign disp_blank = disp_blank_r;
  assign disp_src   = disp_src_r;
  assign disp_ovf   = disp_ovf_r;
  assign disp_upd   = disp_upd_r;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed self-checking bench for seg_disp_ctrl (rotation period shortened to 100).
module tb_seg_disp_ctrl;

  logic         clk;
  logic         rst_n;
  logic [3:0]   src_wr;
  logic [127:0] src_data;
  logic [1:0]   manual_sel;
  logic         auto_rot;
  logic         busy;
  logic [31:0]  disp_bcd;
  logic [7:0]   disp_blank;
  logic [1:0]   disp_src;
  logic         disp_ovf;
  logic         disp_upd;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  int          upd_n_q[$];
  logic [31:0] upd_bcd_q[$];
  logic [7:0]  upd_blank_q[$];
  logic [1:0]  upd_src_q[$];
  logic        upd_ovf_q[$];

  seg_disp_ctrl #(.ROT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .src_wr(src_wr), .src_data(src_data),
    .manual_sel(manual_sel), .auto_rot(auto_rot), .busy(busy),
    .disp_bcd(disp_bcd), .disp_blank(disp_blank), .disp_src(disp_src),
    .disp_ovf(disp_ovf), .disp_upd(disp_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_q();
    busy_cnt = 0;
    upd_n_q.delete(); upd_bcd_q.delete(); upd_blank_q.delete();
    upd_src_q.delete(); upd_ovf_q.delete();
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[32*i +: 32] = v;
    src_wr[i] = 1'b1;
  endtask

  // Step edges n_from..n_to (relative to edge E), releasing writes and logging pulses.
  task automatic watch(input int n_from, input int n_to);
    for (int n = n_from; n <= n_to; n++) begin
      @(posedge clk); #1;
      src_wr = 4'b0000;
      if (busy === 1'b1) busy_cnt++;
      if (disp_upd === 1'b1) begin
        upd_n_q.push_back(n);
        upd_bcd_q.push_back(disp_bcd);
        upd_blank_q.push_back(disp_blank);
        upd_src_q.push_back(disp_src);
        upd_ovf_q.push_back(disp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (disp_bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=0", disp_bcd); end
    checks++; if (disp_blank !== 8'hFE) begin errors++; $display("FAIL reset_blank got=%h exp=fe", disp_blank); end
    checks++; if (disp_src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", disp_src); end
    checks++; if (disp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", disp_ovf); end
    checks++; if (disp_upd !== 1'b0) begin errors++; $display("FAIL reset_upd got=%0b exp=0", disp_upd); end
  endtask

  task automatic test_basic();
    clr_q();
    manual_sel = 2'd0;
    set_src(0, 32'd12);
    watch(0, 45);
    checks++; if (busy_cnt != 33) begin errors++; $display("FAIL basic_busy got=%0d exp=33", busy_cnt); end
    checks++; if (upd_n_q.size() != 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", upd_n_q.size()); end
    else begin
      checks++; if (upd_n_q[0] != 34) begin errors++; $display("FAIL basic_latency got=%0d exp=34", upd_n_q[0]); end
      checks++; if (upd_bcd_q[0] !== 32'h00000012) begin errors++; $display("FAIL basic_bcd got=%h exp=00000012", upd_bcd_q[0]); end
      checks++; if (upd_blank_q[0] !== 8'hFC) begin errors++; $display("FAIL basic_blank got=%h exp=fc", upd_blank_q[0]); end
      checks++; if (upd_ovf_q[0] !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%0b exp=0", upd_ovf_q[0]); end
      checks++; if (upd_src_q[0] !== 2'd0) begin errors++; $display("FAIL basic_src got=%0d exp=0", upd_src_q[0]); end
    end
  endtask

  task automatic test_values();
    logic [31:0] vals [3];
    logic [31:0] bcds [3];
    logic [7:0]  blks [3];
    logic        ovfs [3];
    int          srcs [3];
    vals[0] = 32'd255;       bcds[0] = 32'h00000255; blks[0] = 8'hF8; ovfs[0] = 1'b0; srcs[0] = 2;
    vals[1] = 32'd0;         bcds[1] = 32'h00000000; blks[1] = 8'hFE; ovfs[1] = 1'b0; srcs[1] = 2;
    vals[2] = 32'd123456789; bcds[2] = 32'h23456789; blks[2] = 8'h00; ovfs[2] = 1'b1; srcs[2] = 1;
    for (int t = 0; t < 4; t++) begin
      clr_q();
      if (t < 3) begin
        manual_sel = 2'(srcs[t]);
        set_src(srcs[t], vals[t]);
      end else begin
        set_src(1, 32'hFFFFFFFF);
      end
      watch(0, 45);
      checks++; if (upd_n_q.size() != 1) begin errors++; $display("FAIL val%0d_pulses got=%0d exp=1", t, upd_n_q.size()); end
      else if (t < 3) begin
        checks++; if (upd_bcd_q[0] !== bcds[t]) begin errors++; $display("FAIL val%0d_bcd got=%h exp=%h", t, upd_bcd_q[0], bcds[t]); end
        checks++; if (upd_blank_q[0] !== blks[t]) begin errors++; $display("FAIL val%0d_blank got=%h exp=%h", t, upd_blank_q[0], blks[t]); end
        checks++; if (upd_ovf_q[0] !== ovfs[t]) begin errors++; $display("FAIL val%0d_ovf got=%0b exp=%0b", t, upd_ovf_q[0], ovfs[t]); end
        checks++; if (upd_src_q[0] !== 2'(srcs[t])) begin errors++; $display("FAIL val%0d_src got=%0d exp=%0d", t, upd_src_q[0], srcs[t]); end
      end else begin
        checks++; if (upd_bcd_q[0] !== 32'h94967295) begin errors++; $display("FAIL max_bcd got=%h exp=94967295", upd_bcd_q[0]); end
        checks++; if (upd_ovf_q[0] !== 1'b1) begin errors++; $display("FAIL max_ovf got=%0b exp=1", upd_ovf_q[0]); end
        checks++; if (upd_blank_q[0] !== 8'h00) begin errors++; $display("FAIL max_blank got=%h exp=00", upd_blank_q[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Second write lands mid-conversion.
    clr_q();
    manual_sel = 2'd0;
    set_src(0, 32'd5);
    watch(0, 9);
    set_src(0, 32'd7);
    watch(10, 80);
    checks++; if (upd_n_q.size() != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", upd_n_q.size()); end
    else begin
      checks++; if (upd_n_q[0] != 34 || upd_bcd_q[0] !== 32'h5) begin errors++; $display("FAIL b2b_first got=%0d/%h exp=34/00000005", upd_n_q[0], upd_bcd_q[0]); end
      checks++; if (upd_n_q[1] != 68 || upd_bcd_q[1] !== 32'h7) begin errors++; $display("FAIL b2b_second got=%0d/%h exp=68/00000007", upd_n_q[1], upd_bcd_q[1]); end
    end
    // Second write coincides with the snapshot edge.
    clr_q();
    set_src(0, 32'd5);
    @(posedge clk); #1;
    src_data[31:0] = 32'd9;
    watch(1, 80);
    checks++; if (upd_n_q.size() != 2) begin errors++; $display("FAIL snap_pulses got=%0d exp=2", upd_n_q.size()); end
    else begin
      checks++; if (upd_n_q[0] != 34 || upd_bcd_q[0] !== 32'h5) begin errors++; $display("FAIL snap_first got=%0d/%h exp=34/00000005", upd_n_q[0], upd_bcd_q[0]); end
      checks++; if (upd_n_q[1] != 68 || upd_bcd_q[1] !== 32'h9) begin errors++; $display("FAIL snap_second got=%0d/%h exp=68/00000009", upd_n_q[1], upd_bcd_q[1]); end
    end
  endtask

  task automatic test_rotation();
    clr_q();
    manual_sel = 2'd0;
    set_src(0, 32'd1); set_src(1, 32'd2); set_src(2, 32'd3); set_src(3, 32'd4);
    watch(0, 40);
    checks++; if (upd_n_q.size() != 1 || upd_bcd_q[0] !== 32'h1) begin errors++; $display("FAIL rot_setup pulses=%0d exp=1 value 1", upd_n_q.size()); end
    clr_q();
    auto_rot = 1'b1;
    watch(0, 450);
    checks++; if (upd_n_q.size() != 4) begin errors++; $display("FAIL rot_pulses got=%0d exp=4", upd_n_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (upd_n_q[k] != 134 + 100*k || upd_src_q[k] !== 2'((k + 1) % 4) ||
            upd_bcd_q[k] !== 32'(((k + 1) % 4) + 1)) begin
          errors++;
          $display("FAIL rot_step%0d got n=%0d src=%0d bcd=%h exp n=%0d src=%0d bcd=%0d",
                   k, upd_n_q[k], upd_src_q[k], upd_bcd_q[k], 134 + 100*k, (k + 1) % 4, ((k + 1) % 4) + 1);
        end
      end
    end
    auto_rot = 1'b0;
  endtask

  task automatic test_reset_mid();
    clr_q();
    manual_sel = 2'd1;
    watch(0, 40);
    checks++; if (disp_bcd !== 32'h2 || disp_src !== 2'd1) begin errors++; $display("FAIL rst_pre got=%h/%0d exp=00000002/1", disp_bcd, disp_src); end
    set_src(1, 32'd42);
    watch(0, 19);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%0b exp=1", busy); end
    #2; rst_n = 1'b0; #1;
    test_reset();
    manual_sel = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_q();
    watch(0, 60);
    checks++; if (upd_n_q.size() != 0 || busy_cnt != 0) begin errors++; $display("FAIL rst_quiet pulses=%0d busy=%0d exp=0/0", upd_n_q.size(), busy_cnt); end
    checks++; if (disp_bcd !== 32'h0 || disp_blank !== 8'hFE) begin errors++; $display("FAIL rst_hold got=%h/%h exp=00000000/fe", disp_bcd, disp_blank); end
  endtask

  initial begin
    rst_n = 1'b0; src_wr = 4'b0000; src_data = '0; manual_sel = 2'd0; auto_rot = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_values();
    test_back_to_back();
    test_rotation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
Display controller that sits in front of the 8-digit seven-segment scanner in the Basys3 CPU top level. It holds up to four 32-bit display sources, such as the GCD result, the PC and the switch value. It selects one source, either manually or by timed auto-rotation. It converts the selected unsigned binary value into packed 8-digit BCD with a sequential double-dabble engine, applies leading-zero blanking and an overflow flag, then publishes the result with a one-cycle update strobe.

Parameters:
ROT_CYCLES, 200000000, clocks per source in auto-rotate mode (2 s at 100 MHz); legal range 2..2^32-1

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
src_wr  input  4  per-source write strobe; bit i captures src_data[32i+31:32i]
src_data  input  128  four packed 32-bit source values
manual_sel  input  2  source index used when auto_rot=0
auto_rot  input  1  1 = rotate sources 0→1→2→3→0 every ROT_CYCLES
busy  output  1  conversion in progress (FSM not IDLE)
disp_bcd  output  32  packed BCD; bits [4k+3:4k] = digit k, digit 0 rightmost
disp_blank  output  8  bit k = 1 → digit k is blanked
disp_src  output  2  source index of the currently published value
disp_ovf  output  1  published value ≥ 100000000
disp_upd  output  1  one-cycle pulse when the display outputs change

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset is honoured at any time, including mid-conversion; no disp_upd is issued for an aborted conversion.
- Reset values:
  - src_reg[0..3]=0, dirty=0, cur_src=0, rotation counter=0, FSM=IDLE.
  - busy=0, disp_bcd=0, disp_blank=8'hFE, disp_src=0, disp_ovf=0, disp_upd=0.
- Source capture: on each edge with src_wr[i]=1, src_reg[i]←src_data slice and dirty[i]←1. This applies in every FSM state; multiple bits may be set in one cycle.
- Selection:
  - auto_rot=0: cur_src←manual_sel each edge.
  - auto_rot=1: counter increments each cycle. At ROT_CYCLES-1 it clears and cur_src←cur_src+1 (3 wraps to 0).
  - Counter clears on any auto_rot transition.
- Trigger: in IDLE, start when dirty[cur_src]=1 or cur_src≠disp_src.
- FSM states:
  - IDLE: on trigger, snapshot src_reg[cur_src] into a 32-bit shift register, clear a 40-bit BCD accumulator (10 digits), latch conv_src←cur_src, clear dirty[cur_src], bit counter←0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator digit ≥5, then shift {acc,bin} left by one. After the 32nd iteration (counter=31), go to DONE.
  - DONE: register the outputs, pulse disp_upd for exactly one cycle, return to IDLE.
- DONE output rules:
  - disp_bcd←acc[31:0].
  - disp_ovf←(acc[39:32]≠0).
  - disp_src←conv_src.
  - disp_blank bit k (k=1..7) =1 iff digits k..7 are all zero and disp_ovf=0. Bit 0 is always 0.
- Latency: a src_wr sampled at edge E, with the FSM idle and the source selected, produces disp_upd high during the cycle after edge E+34. busy is high from edge E+1 until edge E+34 inclusive.
- Simultaneous events:
  - src_wr[cur_src] on the IDLE snapshot edge: snapshot takes the old value, and dirty stays 1 (write wins), so a second conversion follows.
  - Writes or selection changes during SHIFT/DONE do not disturb the running conversion. They are serviced from IDLE on the next cycle.
- Output hold: outputs are stable between disp_upd pulses.

Test Plan:
- Reset, then manual_sel=0, src_wr=4'b0001 with value 12 → busy 33 cycles, one disp_upd after edge E+34; disp_bcd=32'h00000012, disp_blank=8'hFC, disp_ovf=0, disp_src=0.
- Write 255 to source 2, then manual_sel=2 → disp_bcd=32'h00000255, blank=8'hF8. Write 0 to source 2 → bcd=0, blank=8'hFE, exactly one pulse per conversion.
- Write 123456789 to source 1, select 1 → disp_ovf=1, disp_bcd=32'h23456789, blank=8'h00. Write 32'hFFFFFFFF → bcd=32'h94967295, ovf=1.
- ROT_CYCLES=100, auto_rot=1, sources hold 1, 2, 3, 4 → disp_src steps 0,1,2,3,0 with disp_upd every 100 cycles; bcd matches each source.
- Write source 0 = 5 at edge E, then source 0 = 7 at E+10 → disp_upd at E+34 with value 5, then a second conversion ending with value 7. Also a write coincident with the IDLE snapshot edge → two conversions.
- Assert rst_n=0 at edge E+20 of a conversion → all outputs return to reset values immediately; no disp_upd pulse afterward without a new trigger.
